axis_pkt_checksum: RTL

Stream stage placed directly downstream of the AXI-Stream `fifo` master port. It forwards each packet word unchanged and accumulates a 32-bit modular sum over the packet. After the last word it appends one trailer word, the negated sum, so the downstream consumer can check integrity by summing all words (trailer included) to zero. It also enforces a maximum packet length and flags truncation.

---
 rtl/pkt_chk_pkg.sv | 14 +
 rtl/axis_out_reg.sv | 43 ++++
 rtl/axis_pkt_checksum.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/pkt_chk_pkg.sv
// Shared types and default sizing for the packet checksum stream stage.
package pkt_chk_pkg;

   localparam int DEF_DATA_WIDTH = 32;
   localparam int DEF_MAX_LEN    = 256;

   // IDLE: no packet open, BODY: packet open, TRAIL: trailer word pending
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BODY  = 2'd1,
      TRAIL = 2'd2
   } state_t;

endpackage

// File: rtl/axis_out_reg.sv
// Single-entry AXI-Stream output register. A load strobe writes a new word;
// the word is held stable until the downstream handshake retires it.
module axis_out_reg #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load_en,
   input  logic [DATA_WIDTH-1:0] d_data,
   input  logic                  d_last,
   output logic                  free,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic                  m_axis_tlast
);

   logic                  vld_p0;
   logic [DATA_WIDTH-1:0] data_p0;
   logic                  last_p0;

   // The register may take a new word when empty or when its word leaves now.
   assign free          = !vld_p0 || m_axis_tready;
   assign m_axis_tvalid = vld_p0;
   assign m_axis_tdata  = data_p0;
   assign m_axis_tlast  = last_p0;

   // Load a new word or retire the current one on handshake; otherwise hold.
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p0  <= 1'b0;
         data_p0 <= '0;
         last_p0 <= 1'b0;
      end else if (load_en) begin
         vld_p0  <= 1'b1;
         data_p0 <= d_data;
         last_p0 <= d_last;
      end else if (m_axis_tready) begin
         vld_p0  <= 1'b0;
      end
   end

endmodule

// File: rtl/axis_pkt_checksum.sv
// Stream stage that forwards packet words unchanged, keeps a modular sum over
// each packet and optionally appends the negated sum as a trailer word, so
// the whole packet including trailer sums to zero. Packets reaching MAX_LEN
// words without tlast are closed early and flagged in the sticky err_trunc.
// Optional build macro PKT_CNT_EN adds the pkt_count output (completed
// packets, counted on output handshakes of tlast words).
module axis_pkt_checksum
   import pkt_chk_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int MAX_LEN    = DEF_MAX_LEN
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  s_axis_tvalid,
   output logic                  s_axis_tready,
   input  logic [DATA_WIDTH-1:0] s_axis_tdata,
   input  logic                  s_axis_tlast,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic                  m_axis_tlast,
   input  logic                  trailer_en,
   input  logic                  err_clr,
   output logic                  err_trunc
`ifdef PKT_CNT_EN
   ,
   output logic [31:0]           pkt_count
`endif
);

   localparam int LEN_W = $clog2(MAX_LEN + 1);

   state_t                state_q, state_d;
   logic [DATA_WIDTH-1:0] sum_q, sum_d;
   logic [LEN_W-1:0]      len_q, len_d, len_nxt;
   logic                  trl_q, trl_d;
   logic                  out_free;
   logic                  accept;
   logic                  eop;
   logic                  trunc_set;
   logic                  wr_en;
   logic [DATA_WIDTH-1:0] wr_data;
   logic                  wr_last;

   // Two's complement negation of the running sum gives the trailer word.
   function automatic logic [DATA_WIDTH-1:0] neg_sum(input logic [DATA_WIDTH-1:0] s);
      return ~s + DATA_WIDTH'(1);
   endfunction

   // No input is taken while the trailer is pending or while in reset.
   assign s_axis_tready = out_free && (state_q != TRAIL) && !rst;
   assign accept        = s_axis_tvalid && s_axis_tready;

   // Next-state, accumulator and output-register write decode.
   always_comb begin
      state_d   = state_q;
      sum_d     = sum_q;
      len_d     = len_q;
      trl_d     = trl_q;
      wr_en     = 1'b0;
      wr_data   = s_axis_tdata;
      wr_last   = 1'b0;
      trunc_set = 1'b0;
      len_nxt   = (state_q == IDLE) ? LEN_W'(1) : len_q + LEN_W'(1);
      eop       = s_axis_tlast || (len_nxt == LEN_W'(MAX_LEN));
      case (state_q)
         IDLE: begin
            // First beat: trailer_en is taken from the bus, not from trl_q.
            if (accept) begin
               trl_d     = trailer_en;
               sum_d     = s_axis_tdata;
               len_d     = len_nxt;
               wr_en     = 1'b1;
               wr_last   = eop && !trailer_en;
               trunc_set = eop && !s_axis_tlast;
               if (eop) begin
                  state_d = trailer_en ? TRAIL : IDLE;
               end else begin
                  state_d = BODY;
               end
            end
         end
         BODY: begin
            if (accept) begin
               sum_d     = sum_q + s_axis_tdata;
               len_d     = len_nxt;
               wr_en     = 1'b1;
               wr_last   = eop && !trl_q;
               trunc_set = eop && !s_axis_tlast;
               if (eop) begin
                  state_d = trl_q ? TRAIL : IDLE;
               end
            end
         end
         TRAIL: begin
            if (out_free) begin
               wr_en   = 1'b1;
               wr_data = neg_sum(sum_q);
               wr_last = 1'b1;
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Packet state, running sum, length and latched trailer enable.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         sum_q   <= '0;
         len_q   <= '0;
         trl_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sum_q   <= sum_d;
         len_q   <= len_d;
         trl_q   <= trl_d;
      end
   end

   // Sticky truncation flag; a new truncation wins over a same-cycle clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         err_trunc <= 1'b0;
      end else if (trunc_set) begin
         err_trunc <= 1'b1;
      end else if (err_clr) begin
         err_trunc <= 1'b0;
      end
   end

`ifdef PKT_CNT_EN
   // Count packets as their final word leaves; wraps naturally at 2^32.
   always_ff @(posedge clk) begin
      if (rst) begin
         pkt_count <= '0;
      end else if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
         pkt_count <= pkt_count + 32'd1;
      end
   end
`endif

   // ---- stage boundary: output register ----
   axis_out_reg #(
      .DATA_WIDTH(DATA_WIDTH)
   ) u_out_reg (
      .clk           (clk),
      .rst           (rst),
      .load_en       (wr_en),
      .d_data        (wr_data),
      .d_last        (wr_last),
      .free          (out_free),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tlast  (m_axis_tlast)
   );

endmodule
